// File: rtl/tl_ram_responder.sv
// TileLink-UL manager endpoint backed by a local 64-bit-wide RAM.
// Serves Get/PutFullData/PutPartialData through a single registered response stage.
module tl_ram_responder #(
  parameter logic [30:0] BASE_ADDR = 31'h0800_0000,
  parameter int          DEPTH     = 512
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [7:0]  auto_in_a_bits_source,
  input  logic [30:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,

  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [7:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TAG_LO = 3 + IDX_W;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [63:0] mem [DEPTH];

  logic             a_fire;
  logic             d_fire;
  logic [IDX_W-1:0] idx;
  logic             hit;
  logic             align;
  logic             is_get;
  logic             is_put;
  logic             deny;
  logic             do_write;

  logic [2:0]  d_opcode_q;
  logic [2:0]  d_size_q;
  logic [7:0]  d_source_q;
  logic        d_denied_q;
  logic        d_corrupt_q;
  logic        d_data_en_q;
  logic [63:0] rd_data_q;

  logic unused_param;
  assign unused_param = ^auto_in_a_bits_param;

  assign a_fire = auto_in_a_valid & auto_in_a_ready;
  assign d_fire = auto_in_d_valid & auto_in_d_ready;

  always_comb begin
    state_d         = state_q;
    auto_in_a_ready = (state_q == EMPTY) | auto_in_d_ready;
    auto_in_d_valid = (state_q == FULL);
    case (state_q)
      EMPTY:   if (a_fire) state_d = FULL;
      FULL:    if (d_fire && !a_fire) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    idx    = auto_in_a_bits_address[3 +: IDX_W];
    hit    = auto_in_a_bits_address[30:TAG_LO] == BASE_ADDR[30:TAG_LO];
    is_get = auto_in_a_bits_opcode == OP_GET;
    is_put = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
             (auto_in_a_bits_opcode == OP_PUT_PARTIAL);
    // Oversized requests report misaligned too; they are denied regardless.
    case (auto_in_a_bits_size)
      3'd0:    align = 1'b1;
      3'd1:    align = auto_in_a_bits_address[0]   == 1'b0;
      3'd2:    align = auto_in_a_bits_address[1:0] == 2'b00;
      3'd3:    align = auto_in_a_bits_address[2:0] == 3'b000;
      default: align = 1'b0;
    endcase
    deny     = !hit || !align || (auto_in_a_bits_size > 3'd3) || !(is_get || is_put);
    do_write = a_fire && is_put && !deny && !auto_in_a_bits_corrupt && !reset;
  end

  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 8; i++) begin
        if (auto_in_a_bits_mask[i]) mem[idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
      end
    end
  end

  // Read every accepted request; d_data_en_q decides whether it is ever shown.
  always_ff @(posedge clock) begin
    if (a_fire) rd_data_q <= mem[idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 3'd0;
      d_source_q  <= 8'd0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (a_fire) begin
        d_opcode_q  <= is_get ? OP_ACK_DATA : OP_ACK;
        d_size_q    <= auto_in_a_bits_size;
        d_source_q  <= auto_in_a_bits_source;
        d_denied_q  <= deny;
        d_corrupt_q <= is_get && deny;
        d_data_en_q <= is_get && !deny;
      end
    end
  end

  assign auto_in_d_bits_opcode  = d_opcode_q;
  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = d_size_q;
  assign auto_in_d_bits_source  = d_source_q;
  assign auto_in_d_bits_sink    = 1'b0;
  assign auto_in_d_bits_denied  = d_denied_q;
  assign auto_in_d_bits_data    = d_data_en_q ? rd_data_q : 64'd0;
  assign auto_in_d_bits_corrupt = d_corrupt_q;

endmodule

// File: tb/tb_tl_ram_responder.sv
// Directed bench for tl_ram_responder: vector table for single transactions,
// hand-written sequences for backpressure, burst and mid-flight reset.
module tb_tl_ram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [30:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_ready;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tl_ram_responder dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_a_bits_corrupt (a_corrupt),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_param   (d_param),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_sink    (d_sink),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_corrupt (d_corrupt)
  );

  typedef struct {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [7:0]  source;
    logic [30:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
    logic [2:0]  exp_opcode;
    logic        exp_denied;
    logic [63:0] exp_data;
    logic        exp_corrupt;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  localparam logic [63:0] WORD_A = 64'h1122_3344_BBBB_BBBB;
  localparam logic [63:0] WORD_B = 64'hEE02_0304_0506_0708;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_valid   = 1'b1;
    a_opcode  = v.opcode;
    a_size    = v.size;
    a_source  = v.source;
    a_address = v.address;
    a_mask    = v.mask;
    a_data    = v.data;
    a_corrupt = v.corrupt;
  endtask

  task automatic setGet(input logic [30:0] addr, input logic [7:0] src);
    a_valid   = 1'b1;
    a_opcode  = 3'd4;
    a_size    = 3'd3;
    a_source  = src;
    a_address = addr;
    a_mask    = 8'hFF;
    a_data    = 64'd0;
    a_corrupt = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " d_valid"}, {63'd0, d_valid}, 64'd0);
    checkOutput({tag, " d_bits"},
                {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt} == '0 ? 64'd0 : 64'd1,
                64'd0);
    checkOutput({tag, " d_data"}, d_data, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //                opc   size  src     address         mask   data                    cor   eop   eden  edata                   ecor
    vecs[0]  = '{3'd0, 3'd3, 8'd5,   31'h0800_0010, 8'hFF, 64'h1122334455667788, 1'b0, 3'd0, 1'b0, 64'd0,                1'b0};
    vecs[1]  = '{3'd4, 3'd3, 8'd5,   31'h0800_0010, 8'h00, 64'd0,                1'b0, 3'd1, 1'b0, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{3'd1, 3'd3, 8'd7,   31'h0800_0010, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0, 3'd0, 1'b0, 64'd0,                1'b0};
    vecs[3]  = '{3'd4, 3'd3, 8'd8,   31'h0800_0010, 8'h00, 64'd0,                1'b0, 3'd1, 1'b0, WORD_A,               1'b0};
    vecs[4]  = '{3'd4, 3'd3, 8'd9,   31'h0400_0000, 8'hFF, 64'd0,                1'b0, 3'd1, 1'b1, 64'd0,                1'b1};
    vecs[5]  = '{3'd4, 3'd2, 8'd10,  31'h0800_0001, 8'h0F, 64'd0,                1'b0, 3'd1, 1'b1, 64'd0,                1'b1};
    vecs[6]  = '{3'd6, 3'd3, 8'd11,  31'h0800_0010, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0, 3'd0, 1'b1, 64'd0,                1'b0};
    vecs[7]  = '{3'd4, 3'd3, 8'd12,  31'h0800_0010, 8'hFF, 64'd0,                1'b0, 3'd1, 1'b0, WORD_A,               1'b0};
    vecs[8]  = '{3'd0, 3'd3, 8'd13,  31'h0800_0010, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd0, 1'b0, 64'd0,                1'b0};
    vecs[9]  = '{3'd4, 3'd3, 8'd14,  31'h0800_0010, 8'hFF, 64'd0,                1'b0, 3'd1, 1'b0, WORD_A,               1'b0};
    vecs[10] = '{3'd0, 3'd3, 8'd15,  31'h0800_1010, 8'hFF, 64'd0,                1'b0, 3'd0, 1'b1, 64'd0,                1'b0};
    vecs[11] = '{3'd0, 3'd2, 8'd16,  31'h0800_0012, 8'hFF, 64'd0,                1'b0, 3'd0, 1'b1, 64'd0,                1'b0};
    vecs[12] = '{3'd4, 3'd4, 8'd17,  31'h0800_0010, 8'hFF, 64'd0,                1'b0, 3'd1, 1'b1, 64'd0,                1'b1};
    vecs[13] = '{3'd4, 3'd1, 8'd18,  31'h0800_0012, 8'h00, 64'd0,                1'b0, 3'd1, 1'b0, WORD_A,               1'b0};
    vecs[14] = '{3'd0, 3'd3, 8'd19,  31'h0800_0FF8, 8'hFF, 64'h0102030405060708, 1'b0, 3'd0, 1'b0, 64'd0,                1'b0};
    vecs[15] = '{3'd1, 3'd3, 8'd20,  31'h0800_0FF8, 8'h80, 64'hEE00000000000000, 1'b0, 3'd0, 1'b0, 64'd0,                1'b0};
    vecs[16] = '{3'd4, 3'd3, 8'd21,  31'h0800_0FF8, 8'h00, 64'd0,                1'b0, 3'd1, 1'b0, WORD_B,               1'b0};
    vecs[17] = '{3'd2, 3'd0, 8'd22,  31'h0800_0FF8, 8'hFF, 64'd0,                1'b0, 3'd0, 1'b1, 64'd0,                1'b0};
    vecs[18] = '{3'd4, 3'd3, 8'd23,  31'h07FF_FFF8, 8'hFF, 64'd0,                1'b0, 3'd1, 1'b1, 64'd0,                1'b1};
    vecs[19] = '{3'd4, 3'd3, 8'hFF,  31'h0800_0FF8, 8'hFF, 64'd0,                1'b0, 3'd1, 1'b0, WORD_B,               1'b0};

    reset     = 1'b1;
    a_valid   = 1'b0;
    a_opcode  = 3'd0;
    a_param   = 3'b101;
    a_size    = 3'd0;
    a_source  = 8'd0;
    a_address = 31'd0;
    a_mask    = 8'd0;
    a_data    = 64'd0;
    a_corrupt = 1'b0;
    d_ready   = 1'b0;

    repeat (3) tick();
    checkIdle("reset");
    checkOutput("reset a_ready", {63'd0, a_ready}, 64'd1);
    reset = 1'b0;
    tick();

    // A-channel activity must not reach D before a clock edge.
    setGet(31'h0800_0010, 8'h33);
    #1;
    checkOutput("no A->D path d_valid", {63'd0, d_valid}, 64'd0);
    a_valid = 1'b0;
    d_ready = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      tick();
      a_valid = 1'b0;
      #1;
      checkOutput($sformatf("vec%0d d_valid", i), {63'd0, d_valid}, 64'd1);
      checkOutput($sformatf("vec%0d opcode", i), {61'd0, d_opcode}, {61'd0, vecs[i].exp_opcode});
      checkOutput($sformatf("vec%0d denied", i), {63'd0, d_denied}, {63'd0, vecs[i].exp_denied});
      checkOutput($sformatf("vec%0d corrupt", i), {63'd0, d_corrupt}, {63'd0, vecs[i].exp_corrupt});
      checkOutput($sformatf("vec%0d data", i), d_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d source", i), {56'd0, d_source}, {56'd0, vecs[i].source});
      checkOutput($sformatf("vec%0d size", i), {61'd0, d_size}, {61'd0, vecs[i].size});
      checkOutput($sformatf("vec%0d param/sink", i), {61'd0, d_param, d_sink}, 64'd0);
      tick();
    end

    // Backpressure: only the first request is taken while d_ready is low.
    d_ready = 1'b0;
    setGet(31'h0800_0010, 8'h40);
    tick();
    for (int k = 0; k < 4; k++) begin
      a_source = 8'h41 + 8'(k);
      #1;
      checkOutput($sformatf("stall%0d d_valid", k), {63'd0, d_valid}, 64'd1);
      checkOutput($sformatf("stall%0d a_ready", k), {63'd0, a_ready}, 64'd0);
      checkOutput($sformatf("stall%0d source", k), {56'd0, d_source}, 64'h40);
      checkOutput($sformatf("stall%0d data", k), d_data, WORD_A);
      tick();
    end

    // Back-to-back burst drains the held response then one per cycle.
    for (int k = 0; k < 8; k++) begin
      d_ready = 1'b1;
      setGet((k % 2 == 1) ? 31'h0800_0FF8 : 31'h0800_0010, 8'h50 + 8'(k));
      #1;
      checkOutput($sformatf("burst%0d a_ready", k), {63'd0, a_ready}, 64'd1);
      tick();
      checkOutput($sformatf("burst%0d d_valid", k), {63'd0, d_valid}, 64'd1);
      checkOutput($sformatf("burst%0d source", k), {56'd0, d_source}, 64'h50 + 64'(k));
      checkOutput($sformatf("burst%0d data", k), d_data, (k % 2 == 1) ? WORD_B : WORD_A);
    end
    a_valid = 1'b0;
    tick();
    checkOutput("burst drained d_valid", {63'd0, d_valid}, 64'd0);

    // Reset with a response pending, plus a Put offered during reset.
    d_ready = 1'b0;
    setGet(31'h0800_0010, 8'h60);
    tick();
    checkOutput("pre-reset d_valid", {63'd0, d_valid}, 64'd1);
    checkOutput("pre-reset source", {56'd0, d_source}, 64'h60);
    reset     = 1'b1;
    d_ready   = 1'b1;
    a_opcode  = 3'd0;
    a_source  = 8'h61;
    a_data    = 64'd0;
    a_mask    = 8'hFF;
    tick();
    checkIdle("mid reset");
    reset   = 1'b0;
    a_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("post-reset%0d d_valid", k), {63'd0, d_valid}, 64'd0);
    end
    setGet(31'h0800_0010, 8'h62);
    tick();
    a_valid = 1'b0;
    #1;
    checkOutput("post-reset get source", {56'd0, d_source}, 64'h62);
    checkOutput("post-reset get data", d_data, WORD_A);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
